// File: rtl/led_seq_ctrl.sv
// LED bank sequencer: steps an 8-LED pattern at a prescaled rate, with run/pause/mode-change arbitration.
// Define LED_SEQ_ACTIVE_LOW_EN to drive oLED inverted for active-low boards.
module led_seq_ctrl #(
  parameter int DIV   = 25_000_000,
  parameter int CNT_W = 25
) (
  input  logic       iCLK,
  input  logic       iRST_N,
  input  logic       iEN,
  input  logic       iPAUSE,
  input  logic [1:0] iMODE,
  input  logic       iMODE_VALID,
  output logic       oMODE_ACK,
  output logic       oSTEP,
  output logic [7:0] oLED,
  output logic [1:0] oDBG_STATE
);

  // Mode handshake: a request is taken when iMODE_VALID=1 and oMODE_ACK=0;
  // the ack pulses for one cycle and the requester drops valid after seeing it.

  typedef enum logic [1:0] {S_IDLE = 2'd0, S_RUN = 2'd1, S_HOLD = 2'd2} state_e;

`ifdef LED_SEQ_ACTIVE_LOW_EN
  localparam logic [7:0] LED_XOR = 8'hFF;
`else
  localparam logic [7:0] LED_XOR = 8'h00;
`endif

  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DIV - 1);
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  state_e           state_q, state_d;
  logic [1:0]       mode_q, mode_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             dir_q, dir_d;   // 0 = left, 1 = right
  logic [7:0]       pat_q, pat_d;
  logic [7:0]       led_q, led_d;
  logic             ack_q, ack_d;
  logic             step_q, step_d;
  logic             accept;
  logic             tick;

  function automatic logic [7:0] seed(input logic [1:0] m);
    return (m == 2'd0 || m == 2'd1) ? 8'h01 : 8'h00;
  endfunction

  assign accept = iMODE_VALID && !ack_q;
  assign tick   = (cnt_q == CNT_MAX);

  always_comb begin
    state_d = state_q;
    mode_d  = mode_q;
    cnt_d   = cnt_q;
    dir_d   = dir_q;
    pat_d   = pat_q;
    ack_d   = 1'b0;
    step_d  = 1'b0;
    case (state_q)
      S_IDLE: begin
        cnt_d = '0;
        pat_d = 8'h00;
        dir_d = 1'b0;
        if (accept) begin
          mode_d = iMODE;
          ack_d  = 1'b1;
        end
        if (iEN) begin
          state_d = S_RUN;
          pat_d   = seed(mode_d);
        end
      end
      default: begin
        if (!iEN) begin
          state_d = S_IDLE;
          cnt_d   = '0;
          dir_d   = 1'b0;
          pat_d   = 8'h00;
        end else if (accept) begin
          // A new mode restarts the period and clears any pause.
          state_d = S_RUN;
          mode_d  = iMODE;
          ack_d   = 1'b1;
          cnt_d   = '0;
          dir_d   = 1'b0;
          pat_d   = seed(iMODE);
        end else if (state_q == S_RUN) begin
          cnt_d = tick ? '0 : cnt_q + CNT_ONE;
          if (tick) begin
            step_d = 1'b1;
            case (mode_q)
              2'd0: pat_d = {pat_q[6:0], pat_q[7]};
              2'd1: begin
                if (!dir_q && pat_q == 8'h80) begin
                  dir_d = 1'b1;
                  pat_d = 8'h40;
                end else if (dir_q && pat_q == 8'h01) begin
                  dir_d = 1'b0;
                  pat_d = 8'h02;
                end else begin
                  pat_d = dir_q ? (pat_q >> 1) : (pat_q << 1);
                end
              end
              2'd2:    pat_d = ~pat_q;
              default: pat_d = pat_q + 8'd1;
            endcase
          end
          if (iPAUSE) state_d = S_HOLD;
        end else begin
          if (!iPAUSE) state_d = S_RUN;
        end
      end
    endcase
    led_d = pat_d ^ LED_XOR;
  end

  always_ff @(posedge iCLK or negedge iRST_N) begin
    if (!iRST_N) begin
      state_q <= S_IDLE;
      mode_q  <= 2'd0;
      cnt_q   <= '0;
      dir_q   <= 1'b0;
      pat_q   <= 8'h00;
      led_q   <= LED_XOR;
      ack_q   <= 1'b0;
      step_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      mode_q  <= mode_d;
      cnt_q   <= cnt_d;
      dir_q   <= dir_d;
      pat_q   <= pat_d;
      led_q   <= led_d;
      ack_q   <= ack_d;
      step_q  <= step_d;
    end
  end

  assign oMODE_ACK  = ack_q;
  assign oSTEP      = step_q;
  assign oLED       = led_q;
  assign oDBG_STATE = state_q;

endmodule

// File: tb/tb_led_seq_ctrl.sv
// Directed bench for led_seq_ctrl with DIV=4: patterns, handshake, pause, collisions and async reset.
module tb_led_seq_ctrl;

  logic       clk;
  logic       rst_n;
  logic       en;
  logic       pause;
  logic [1:0] mode;
  logic       mode_valid;
  logic       mode_ack;
  logic       step;
  logic [7:0] led;
  logic [1:0] dbg_state;

  int n_cmp = 0;
  int n_err = 0;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_RUN  = 2'd1;
  localparam logic [1:0] ST_HOLD = 2'd2;

`ifdef LED_SEQ_ACTIVE_LOW_EN
  localparam logic [7:0] POL = 8'hFF;
`else
  localparam logic [7:0] POL = 8'h00;
`endif

  led_seq_ctrl #(.DIV(4), .CNT_W(3)) dut (
    .iCLK       (clk),
    .iRST_N     (rst_n),
    .iEN        (en),
    .iPAUSE     (pause),
    .iMODE      (mode),
    .iMODE_VALID(mode_valid),
    .oMODE_ACK  (mode_ack),
    .oSTEP      (step),
    .oLED       (led),
    .oDBG_STATE (dbg_state)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic test_reset;
    rst_n = 1'b0; en = 1'b0; pause = 1'b0; mode = 2'd0; mode_valid = 1'b0;
    #3;
    n_cmp++; if (led !== POL) begin n_err++; $display("FAIL reset_led got %h exp %h", led, POL); end
    n_cmp++; if (mode_ack !== 1'b0) begin n_err++; $display("FAIL reset_ack got %b exp 0", mode_ack); end
    n_cmp++; if (step !== 1'b0) begin n_err++; $display("FAIL reset_step got %b exp 0", step); end
    n_cmp++; if (dbg_state !== ST_IDLE) begin n_err++; $display("FAIL reset_state got %0d exp 0", dbg_state); end
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_walk;
    logic [7:0] e;
    @(negedge clk); en = 1'b1;
    @(negedge clk);
    n_cmp++; if (led !== (8'h01 ^ POL)) begin n_err++; $display("FAIL walk_seed got %h exp %h", led, 8'h01 ^ POL); end
    n_cmp++; if (dbg_state !== ST_RUN) begin n_err++; $display("FAIL walk_state got %0d exp 1", dbg_state); end
    for (int c = 1; c <= 32; c++) begin
      @(negedge clk);
      n_cmp++; if (step !== (c % 4 == 0)) begin n_err++; $display("FAIL walk_step c=%0d got %b", c, step); end
      if (c % 4 == 0) begin
        e = 8'h01 << ((c / 4) % 8);
        n_cmp++; if (led !== (e ^ POL)) begin n_err++; $display("FAIL walk_led c=%0d got %h exp %h", c, led, e ^ POL); end
      end
    end
  endtask

  task automatic test_pingpong;
    logic [7:0] e;
    int k;
    mode = 2'd1; mode_valid = 1'b1;
    @(negedge clk);
    n_cmp++; if (mode_ack !== 1'b1) begin n_err++; $display("FAIL pp_ack got %b exp 1", mode_ack); end
    n_cmp++; if (led !== (8'h01 ^ POL)) begin n_err++; $display("FAIL pp_seed got %h exp %h", led, 8'h01 ^ POL); end
    n_cmp++; if (step !== 1'b0) begin n_err++; $display("FAIL pp_step0 got %b exp 0", step); end
    mode_valid = 1'b0;
    for (int c = 1; c <= 64; c++) begin
      @(negedge clk);
      if (c == 1) begin
        n_cmp++; if (mode_ack !== 1'b0) begin n_err++; $display("FAIL pp_ack_pulse got %b exp 0", mode_ack); end
      end
      n_cmp++; if (step !== (c % 4 == 0)) begin n_err++; $display("FAIL pp_step c=%0d got %b", c, step); end
      if (c % 4 == 0) begin
        k = c / 4;
        if (k <= 7)       e = 8'h01 << k;
        else if (k <= 14) e = 8'h01 << (14 - k);
        else              e = 8'h01 << (k - 14);
        n_cmp++; if (led !== (e ^ POL)) begin n_err++; $display("FAIL pp_led k=%0d got %h exp %h", k, led, e ^ POL); end
      end
    end
  endtask

  task automatic test_count;
    logic [7:0] e;
    mode = 2'd3; mode_valid = 1'b1;
    @(negedge clk);
    n_cmp++; if (mode_ack !== 1'b1) begin n_err++; $display("FAIL cnt_ack got %b exp 1", mode_ack); end
    n_cmp++; if (led !== (8'h00 ^ POL)) begin n_err++; $display("FAIL cnt_seed got %h exp %h", led, POL); end
    mode_valid = 1'b0;
    for (int c = 1; c <= 1024; c++) begin
      @(negedge clk);
      n_cmp++; if (step !== (c % 4 == 0)) begin n_err++; $display("FAIL cnt_step c=%0d got %b", c, step); end
      if (c % 4 == 0) begin
        e = 8'((c / 4) % 256);
        n_cmp++; if (led !== (e ^ POL)) begin n_err++; $display("FAIL cnt_led c=%0d got %h exp %h", c, led, e ^ POL); end
      end
    end
  endtask

  task automatic test_blink;
    logic [7:0] e;
    mode = 2'd2; mode_valid = 1'b1;
    @(negedge clk);
    n_cmp++; if (mode_ack !== 1'b1) begin n_err++; $display("FAIL blink_ack got %b exp 1", mode_ack); end
    n_cmp++; if (led !== (8'h00 ^ POL)) begin n_err++; $display("FAIL blink_seed got %h exp %h", led, POL); end
    mode_valid = 1'b0;
    for (int c = 1; c <= 16; c++) begin
      @(negedge clk);
      n_cmp++; if (step !== (c % 4 == 0)) begin n_err++; $display("FAIL blink_step c=%0d got %b", c, step); end
      if (c % 4 == 0) begin
        e = ((c / 4) % 2 == 1) ? 8'hFF : 8'h00;
        n_cmp++; if (led !== (e ^ POL)) begin n_err++; $display("FAIL blink_led c=%0d got %h exp %h", c, led, e ^ POL); end
      end
    end
  endtask

  // Pause raised when cnt=2: the rising cycle still counts, the release cycle does not.
  task automatic test_pause;
    repeat (2) @(negedge clk);
    pause = 1'b1;
    for (int i = 1; i <= 10; i++) begin
      @(negedge clk);
      n_cmp++; if (step !== 1'b0) begin n_err++; $display("FAIL pause_step i=%0d got %b exp 0", i, step); end
      n_cmp++; if (led !== (8'h00 ^ POL)) begin n_err++; $display("FAIL pause_led i=%0d got %h exp %h", i, led, POL); end
      n_cmp++; if (dbg_state !== ST_HOLD) begin n_err++; $display("FAIL pause_state i=%0d got %0d exp 2", i, dbg_state); end
    end
    pause = 1'b0;
    @(negedge clk);
    n_cmp++; if (step !== 1'b0) begin n_err++; $display("FAIL resume_step0 got %b exp 0", step); end
    n_cmp++; if (dbg_state !== ST_RUN) begin n_err++; $display("FAIL resume_state got %0d exp 1", dbg_state); end
    @(negedge clk);
    n_cmp++; if (step !== 1'b1) begin n_err++; $display("FAIL resume_step got %b exp 1", step); end
    n_cmp++; if (led !== (8'hFF ^ POL)) begin n_err++; $display("FAIL resume_led got %h exp %h", led, 8'hFF ^ POL); end
  endtask

  task automatic test_tick_collision;
    repeat (3) @(negedge clk);
    mode = 2'd0; mode_valid = 1'b1;
    @(negedge clk);
    n_cmp++; if (mode_ack !== 1'b1) begin n_err++; $display("FAIL coll_ack got %b exp 1", mode_ack); end
    n_cmp++; if (step !== 1'b0) begin n_err++; $display("FAIL coll_step got %b exp 0", step); end
    n_cmp++; if (led !== (8'h01 ^ POL)) begin n_err++; $display("FAIL coll_led got %h exp %h", led, 8'h01 ^ POL); end
    @(negedge clk);
    n_cmp++; if (mode_ack !== 1'b0) begin n_err++; $display("FAIL coll_reack got %b exp 0", mode_ack); end
    mode_valid = 1'b0;
    repeat (2) begin
      @(negedge clk);
      n_cmp++; if (step !== 1'b0) begin n_err++; $display("FAIL coll_gap_step got %b exp 0", step); end
    end
    @(negedge clk);
    n_cmp++; if (step !== 1'b1) begin n_err++; $display("FAIL coll_next_step got %b exp 1", step); end
    n_cmp++; if (led !== (8'h02 ^ POL)) begin n_err++; $display("FAIL coll_next_led got %h exp %h", led, 8'h02 ^ POL); end
  endtask

  task automatic test_en_drop;
    en = 1'b0; mode = 2'd3; mode_valid = 1'b1;
    @(negedge clk);
    n_cmp++; if (mode_ack !== 1'b0) begin n_err++; $display("FAIL endrop_ack got %b exp 0", mode_ack); end
    n_cmp++; if (led !== POL) begin n_err++; $display("FAIL endrop_led got %h exp %h", led, POL); end
    n_cmp++; if (dbg_state !== ST_IDLE) begin n_err++; $display("FAIL endrop_state got %0d exp 0", dbg_state); end
    mode_valid = 1'b0; en = 1'b1;
    @(negedge clk);
    n_cmp++; if (led !== (8'h01 ^ POL)) begin n_err++; $display("FAIL endrop_mode_kept got %h exp %h", led, 8'h01 ^ POL); end
    en = 1'b0;
    @(negedge clk);
    mode = 2'd2; mode_valid = 1'b1;
    @(negedge clk);
    n_cmp++; if (mode_ack !== 1'b1) begin n_err++; $display("FAIL idle_ack got %b exp 1", mode_ack); end
    n_cmp++; if (led !== POL) begin n_err++; $display("FAIL idle_led got %h exp %h", led, POL); end
    n_cmp++; if (dbg_state !== ST_IDLE) begin n_err++; $display("FAIL idle_state got %0d exp 0", dbg_state); end
    mode_valid = 1'b0; en = 1'b1;
    @(negedge clk);
    n_cmp++; if (dbg_state !== ST_RUN) begin n_err++; $display("FAIL idle_run got %0d exp 1", dbg_state); end
    repeat (3) @(negedge clk);
    @(negedge clk);
    n_cmp++; if (step !== 1'b1) begin n_err++; $display("FAIL idle_mode_step got %b exp 1", step); end
    n_cmp++; if (led !== (8'hFF ^ POL)) begin n_err++; $display("FAIL idle_mode_led got %h exp %h", led, 8'hFF ^ POL); end
  endtask

  task automatic test_async_reset;
    mode = 2'd1; mode_valid = 1'b1;
    @(posedge clk); #1;
    n_cmp++; if (mode_ack !== 1'b1) begin n_err++; $display("FAIL arst_pre_ack got %b exp 1", mode_ack); end
    #2 rst_n = 1'b0;
    #1;
    n_cmp++; if (mode_ack !== 1'b0) begin n_err++; $display("FAIL arst_ack got %b exp 0", mode_ack); end
    n_cmp++; if (led !== POL) begin n_err++; $display("FAIL arst_led got %h exp %h", led, POL); end
    n_cmp++; if (dbg_state !== ST_IDLE) begin n_err++; $display("FAIL arst_state got %0d exp 0", dbg_state); end
    mode_valid = 1'b0;
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk);
    repeat (4) @(posedge clk);
    #1;
    n_cmp++; if (step !== 1'b1) begin n_err++; $display("FAIL arst_run_step got %b exp 1", step); end
    n_cmp++; if (led !== (8'h02 ^ POL)) begin n_err++; $display("FAIL arst_run_led got %h exp %h", led, 8'h02 ^ POL); end
    #2 rst_n = 1'b0;
    #1;
    n_cmp++; if (step !== 1'b0) begin n_err++; $display("FAIL arst2_step got %b exp 0", step); end
    n_cmp++; if (led !== POL) begin n_err++; $display("FAIL arst2_led got %h exp %h", led, POL); end
    @(negedge clk); rst_n = 1'b1;
  endtask

  initial begin
    test_reset();
    test_walk();
    test_pingpong();
    test_count();
    test_blink();
    test_pause();
    test_tick_collision();
    test_en_drop();
    test_async_reset();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
